// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the line-level bit
// constants used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Bit-timing counters for the UART receiver.
// edgeCnt walks 0..OVERSAMPLE-1 inside each bit and bitCnt walks the data bits.
// The module produces a strobe at the last oversample tick of a bit and at the
// sampling tick chosen by the receiver.
module uart_rx_edge_bit_cnt
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 8,
  parameter int DATA_W     = 8,
  parameter int SAMPLE_IDX = OVERSAMPLE / 2
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_clr,
  input  logic i_bitInc,
  output logic [((DATA_W > 1) ? $clog2(DATA_W) : 1)-1:0] o_bitCnt,
  output logic o_bitEnd,
  output logic o_samplePt
);

  localparam int EW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [EW-1:0] r_edgeCnt;
  logic [BW-1:0] r_bitCnt;
  logic          w_bitEnd;

  assign w_bitEnd   = (r_edgeCnt == EW'(OVERSAMPLE - 1));
  assign o_bitEnd   = w_bitEnd;
  assign o_samplePt = (r_edgeCnt == EW'(SAMPLE_IDX));
  assign o_bitCnt   = r_bitCnt;

  // Advance the oversample tick; at the end of a bit wrap it and step the data-bit index.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_clr) begin
      r_edgeCnt <= '0;
      r_bitCnt  <= '0;
    end else if (i_en) begin
      if (w_bitEnd) begin
        r_edgeCnt <= '0;
        if (i_bitInc) begin
          r_bitCnt <= (r_bitCnt == BW'(DATA_W - 1)) ? '0 : r_bitCnt + 1'b1;
        end
      end else begin
        r_edgeCnt <= r_edgeCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start bit, DATA_W data bits LSB first, optional parity, one stop bit.
// The serial input is synchronised, oversampled and checked for parity and stop errors.
// Optional build macro UART_RX_MAJORITY_EN decides each bit by a 2-of-3 vote around
// the bit centre, one tick later than the single-sample build.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 8,
  parameter int DATA_W     = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RX_IN,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  output logic [DATA_W-1:0] P_DATA,
  output logic              Data_Valid,
  output logic              par_err,
  output logic              stp_err,
  output logic              busy
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic              r_sync1;
  logic              r_sync2;
  logic              w_rxS;
  logic              w_bit;
  rx_state_e         r_state;
  rx_state_e         w_nextState;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_pData;
  logic              r_dataValid;
  logic              r_parErr;
  logic              r_stpErr;
  logic              r_parEn;
  logic              r_parTyp;
  logic              r_frameErr;
  logic              w_cntEn;
  logic              w_cntClr;
  logic              w_bitInc;
  logic              w_latchCfg;
  logic              w_shiftEn;
  logic              w_parFail;
  logic              w_stopFail;
  logic              w_frameDone;
  logic [BW-1:0]     w_bitCnt;
  logic              w_bitEnd;
  logic              w_samplePt;

  assign w_rxS = r_sync2;

`ifdef UART_RX_MAJORITY_EN
  localparam int SAMPLE_IDX = OVERSAMPLE / 2 + 1;

  logic [1:0] r_hist;

  // Keep the two previous synchronised samples so the vote can see three ticks.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hist <= 2'b11;
    end else begin
      r_hist <= {r_hist[0], w_rxS};
    end
  end

  assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rxS) | (r_hist[0] & w_rxS);
`else
  localparam int SAMPLE_IDX = OVERSAMPLE / 2;

  assign w_bit = w_rxS;
`endif

  // Two-flop synchroniser for the asynchronous serial line, idling high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= RX_IN;
      r_sync2 <= r_sync1;
    end
  end

  uart_rx_edge_bit_cnt #(
    .OVERSAMPLE (OVERSAMPLE),
    .DATA_W     (DATA_W),
    .SAMPLE_IDX (SAMPLE_IDX)
  ) u_cnt (
    .i_clock    (CLK),
    .i_reset    (RST),
    .i_en       (w_cntEn),
    .i_clr      (w_cntClr),
    .i_bitInc   (w_bitInc),
    .o_bitCnt   (w_bitCnt),
    .o_bitEnd   (w_bitEnd),
    .o_samplePt (w_samplePt)
  );

  // Frame state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode plus the strobes that drive the datapath and counters.
  always_comb begin
    w_nextState = r_state;
    w_cntEn     = 1'b1;
    w_cntClr    = 1'b0;
    w_bitInc    = 1'b0;
    w_latchCfg  = 1'b0;
    w_shiftEn   = 1'b0;
    w_parFail   = 1'b0;
    w_stopFail  = 1'b0;
    w_frameDone = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rxS == START_BIT) begin
          w_nextState = START;
          w_latchCfg  = 1'b1;
        end else begin
          w_cntEn  = 1'b0;
          w_cntClr = 1'b1;
        end
      end
      START: begin
        if (w_samplePt && (w_bit != START_BIT)) begin
          w_nextState = IDLE;
          w_cntClr    = 1'b1;
        end else if (w_bitEnd) begin
          w_nextState = DATA;
        end
      end
      DATA: begin
        w_bitInc = 1'b1;
        if (w_samplePt) begin
          w_shiftEn = 1'b1;
        end
        if (w_bitEnd && (w_bitCnt == BW'(DATA_W - 1))) begin
          w_nextState = r_parEn ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (w_samplePt && (w_bit != ((^r_shift) ^ r_parTyp))) begin
          w_parFail = 1'b1;
        end
        if (w_bitEnd) begin
          w_nextState = STOP;
        end
      end
      STOP: begin
        if (w_samplePt) begin
          w_nextState = IDLE;
          w_cntClr    = 1'b1;
          if (w_bit == STOP_BIT) begin
            w_frameDone = !r_frameErr;
          end else begin
            w_stopFail = 1'b1;
          end
        end
      end
      default: begin
        w_nextState = IDLE;
        w_cntClr    = 1'b1;
      end
    endcase
  end

  // Shift register, frame configuration latch, sticky error flag and result pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_shift     <= '0;
      r_pData     <= '0;
      r_dataValid <= 1'b0;
      r_parErr    <= 1'b0;
      r_stpErr    <= 1'b0;
      r_parEn     <= 1'b0;
      r_parTyp    <= 1'b0;
      r_frameErr  <= 1'b0;
    end else begin
      r_dataValid <= w_frameDone;
      r_parErr    <= w_parFail;
      r_stpErr    <= w_stopFail;
      if (w_latchCfg) begin
        r_parEn    <= PAR_EN;
        r_parTyp   <= PAR_TYP;
        r_frameErr <= 1'b0;
      end else if (w_parFail) begin
        r_frameErr <= 1'b1;
      end
      if (w_shiftEn) begin
        r_shift <= {w_bit, r_shift[DATA_W-1:1]};
      end
      if (w_frameDone) begin
        r_pData <= r_shift;
      end
    end
  end

  assign P_DATA     = r_pData;
  assign Data_Valid = r_dataValid;
  assign par_err    = r_parErr;
  assign stp_err    = r_stpErr;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames followed by random frames.
// Expected pulses go into a scoreboard queue when a frame is launched; an
// independent monitor pops and compares them, including the pulse cycle.
// Honours UART_RX_MAJORITY_EN for the extra tick of latency and a glitch test.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int OS = 8;
  localparam int DW = 8;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic          RX_IN;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid;
  logic          par_err;
  logic          stp_err;
  logic          busy;

  typedef struct {
    logic          dv;
    logic          pe;
    logic          se;
    logic [DW-1:0] data;
    int unsigned   cyc;
  } expEvent_t;

  expEvent_t     expQ[$];
  int            nChecks = 0;
  int            nFails  = 0;
  int unsigned   cyc     = 0;
  logic [DW-1:0] modelPData = '0;

  uart_rx #(.OVERSAMPLE(OS), .DATA_W(DW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .busy       (busy)
  );

  // Free-running clock.
  always #5 CLK = ~CLK;

  // Rising-edge counter used to time-stamp expected pulses.
  always @(posedge CLK) cyc <= cyc + 1;

  // Single comparison with failure report.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every result pulse must match the oldest expected event.
  always @(negedge CLK) begin : monitor
    expEvent_t e;
    if (Data_Valid || par_err || stp_err) begin
      if (expQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("[TB] FAIL unexpectedPulse: dv=%0b pe=%0b se=%0b, expected none (cycle %0d)",
                 Data_Valid, par_err, stp_err, cyc);
      end else begin
        e = expQ.pop_front();
        checkOutput("pulseKind", {29'd0, Data_Valid, par_err, stp_err}, {29'd0, e.dv, e.pe, e.se});
        checkOutput("pData", {24'd0, P_DATA}, {24'd0, e.data});
        checkOutput("pulseCycle", cyc, e.cyc);
      end
    end
  end

  // Hold the line idle for n cycles; entry and exit are 1 time unit after a rising edge.
  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Drive one frame and push the pulses the receiver owes for it.
  task automatic applyStimulus(input logic [DW-1:0] data, input logic parEn, input logic parTyp,
                               input logic badPar, input logic badStop,
                               input int glitchBit, input bit scramble);
    logic        bits[$];
    logic        parBit;
    int          nb;
    int unsigned k;
    expEvent_t   e;
    parBit = (^data) ^ parTyp;
    if (badPar) parBit = ~parBit;
    bits = {};
    bits.push_back(START_BIT);
    for (int i = 0; i < DW; i++) bits.push_back(data[i]);
    if (parEn) bits.push_back(parBit);
    bits.push_back(badStop ? 1'b0 : STOP_BIT);
    nb = parEn ? DW + 2 : DW + 1;
    PAR_EN  = parEn;
    PAR_TYP = parTyp;
    k = cyc;
    if (parEn && badPar) begin
      e.dv = 1'b0; e.pe = 1'b1; e.se = 1'b0; e.data = modelPData;
      e.cyc = k + 3 + (DW + 1) * OS + OS / 2 + MAJ;
      expQ.push_back(e);
    end
    if (badStop) begin
      e.dv = 1'b0; e.pe = 1'b0; e.se = 1'b1; e.data = modelPData;
      e.cyc = k + 3 + nb * OS + OS / 2 + MAJ;
      expQ.push_back(e);
    end else if (!(parEn && badPar)) begin
      modelPData = data;
      e.dv = 1'b1; e.pe = 1'b0; e.se = 1'b0; e.data = data;
      e.cyc = k + 3 + nb * OS + OS / 2 + MAJ;
      expQ.push_back(e);
    end
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c < OS; c++) begin
        RX_IN = (b == glitchBit && c == OS / 2) ? ~bits[b] : bits[b];
        if (scramble && b == 4 && c == 0) begin
          PAR_EN  = 1'($urandom);
          PAR_TYP = 1'($urandom);
        end
        @(posedge CLK);
        #1;
      end
    end
    RX_IN = 1'b1;
  endtask

  // Confirm the frame's pulses have all been seen and the receiver is idle.
  task automatic checkSettled(input string tag);
    idle(2 * OS);
    checkOutput({tag, "_drained"}, expQ.size(), 0);
    checkOutput({tag, "_busyLow"}, {31'd0, busy}, 0);
  endtask

  // Hard stop if anything hangs.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Main stimulus sequence.
  initial begin
    int busyCnt;
    RST     = 1'b1;
    RX_IN   = 1'b1;
    PAR_EN  = 1'b0;
    PAR_TYP = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    checkOutput("rstPData", {24'd0, P_DATA}, 0);
    checkOutput("rstDataValid", {31'd0, Data_Valid}, 0);
    checkOutput("rstParErr", {31'd0, par_err}, 0);
    checkOutput("rstStpErr", {31'd0, stp_err}, 0);
    checkOutput("rstBusy", {31'd0, busy}, 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    idle(4);

    $display("[TB] test 1: no parity 0xA5");
    applyStimulus(8'hA5, 1'b0, PAR_EVEN, 1'b0, 1'b0, -1, 1'b0);
    checkSettled("t1");
    checkOutput("t1_pData", {24'd0, P_DATA}, 32'hA5);

    $display("[TB] test 2: even parity good and bad");
    applyStimulus(8'hA5, 1'b1, PAR_EVEN, 1'b0, 1'b0, -1, 1'b0);
    checkSettled("t2a");
    applyStimulus(8'hA5, 1'b1, PAR_EVEN, 1'b1, 1'b0, -1, 1'b0);
    checkSettled("t2b");

    $display("[TB] test 3: odd parity 0x07, then 0x3C with bad stop");
    applyStimulus(8'h07, 1'b1, PAR_ODD, 1'b0, 1'b0, -1, 1'b0);
    checkSettled("t3a");
    applyStimulus(8'h3C, 1'b1, PAR_ODD, 1'b0, 1'b1, -1, 1'b0);
    checkSettled("t3b");
    checkOutput("t3_pDataKept", {24'd0, P_DATA}, 32'h07);

    $display("[TB] test 4: short start glitch");
    RX_IN = 1'b0;
    repeat (3) begin
      @(posedge CLK);
      #1;
    end
    RX_IN = 1'b1;
    busyCnt = 0;
    for (int i = 0; i < 4 * OS; i++) begin
      @(negedge CLK);
      if (busy) busyCnt++;
    end
    @(posedge CLK);
    #1;
    checkOutput("t4_busyAtMost5", {31'd0, busyCnt <= 5}, 1);
    checkOutput("t4_busySeen", {31'd0, busyCnt >= 1}, 1);
    checkSettled("t4");

    $display("[TB] test 5: back-to-back 0x55, 0xAA");
    applyStimulus(8'h55, 1'b0, PAR_EVEN, 1'b0, 1'b0, -1, 1'b0);
    applyStimulus(8'hAA, 1'b0, PAR_EVEN, 1'b0, 1'b0, -1, 1'b0);
    checkSettled("t5");

    $display("[TB] test 6: reset mid-frame, then 0x81");
    PAR_EN = 1'b0;
    RX_IN  = 1'b0;
    repeat (OS) begin
      @(posedge CLK);
      #1;
    end
    RX_IN = 1'b1;
    repeat (3 * OS) begin
      @(posedge CLK);
      #1;
    end
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkOutput("t6_rstBusy", {31'd0, busy}, 0);
    checkOutput("t6_rstPData", {24'd0, P_DATA}, 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    modelPData = '0;
    idle(3 * OS);
    applyStimulus(8'h81, 1'b0, PAR_EVEN, 1'b0, 1'b0, -1, 1'b0);
    checkSettled("t6");

`ifdef UART_RX_MAJORITY_EN
    $display("[TB] majority: single-tick glitches at the sample point");
    applyStimulus(8'hA5, 1'b0, PAR_EVEN, 1'b0, 1'b0, 4, 1'b0);
    applyStimulus(8'h3C, 1'b1, PAR_ODD, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(8'h96, 1'b1, PAR_EVEN, 1'b0, 1'b0, 9, 1'b0);
    checkSettled("maj");
`endif

    $display("[TB] random frames");
    for (int n = 0; n < 40; n++) begin
      logic [DW-1:0] d;
      logic          pe;
      logic          pt;
      logic          bp;
      logic          bs;
      int            gap;
      d   = DW'($urandom);
      pe  = 1'($urandom_range(0, 1));
      pt  = 1'($urandom_range(0, 1));
      bp  = pe && ($urandom_range(0, 4) == 0);
      bs  = ($urandom_range(0, 5) == 0);
      applyStimulus(d, pe, pt, bp, bs, -1, 1'b1);
      if (bs) gap = 2 * OS;
      else if ($urandom_range(0, 1) == 1) gap = 0;
      else gap = $urandom_range(1, 3 * OS);
      idle(gap);
    end
    checkSettled("rand");

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
